// File: rtl/conversor_bcd_resultado_pkg.sv
// ============================================================================
//  conversor_bcd_resultado_pkg
//  Shared FSM encoding and default widths for the BCD result converter.
//  Rev 1.0
// ============================================================================
`default_nettype none

package conversor_bcd_resultado_pkg;

    localparam int LARGURA_PADRAO = 8;
    localparam int DIGITOS_PADRAO = 3;
    localparam int LARGURA_BCD    = 4 * DIGITOS_PADRAO;

    typedef enum logic [0:0] {
        OCIOSO   = 1'b0,
        CONVERTE = 1'b1
    } estado_t;

endpackage : conversor_bcd_resultado_pkg

`default_nettype wire

// File: rtl/ajuste_mais3.sv
// ============================================================================
//  ajuste_mais3
//  Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
//  Rev 1.0
// ============================================================================
`default_nettype none

module ajuste_mais3 (
    input  logic [3:0] digito_in,
    output logic [3:0] digito_out
);

    assign digito_out = (digito_in >= 4'd5) ? (digito_in + 4'd3) : digito_in;

endmodule : ajuste_mais3

`default_nettype wire

// File: rtl/conversor_bcd_resultado.sv
// ============================================================================
//  conversor_bcd_resultado
//  Sequential binary-to-BCD converter for the divider's quotient and remainder.
//  Rev 1.0
// ============================================================================
`default_nettype none

module conversor_bcd_resultado
    import conversor_bcd_resultado_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int DIGITOS = DIGITOS_PADRAO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LARGURA-1:0]     quociente,
    input  logic [LARGURA-1:0]     resto,
    input  logic                   div_zero,
    output logic [4*DIGITOS-1:0]   bcd_q,
    output logic [4*DIGITOS-1:0]   bcd_r,
    output logic                   erro,
    output logic                   busy,
    output logic                   valid
);

    localparam int                 LARG_BCD  = 4 * DIGITOS;
    localparam int                 CNT_W     = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [CNT_W-1:0]   c_CNT_ULT = CNT_W'(LARGURA - 1);

    estado_t               r_estado;
    logic [CNT_W-1:0]      r_cnt;
    logic [LARGURA-1:0]    r_bin_q;
    logic [LARGURA-1:0]    r_bin_r;
    logic [LARG_BCD-1:0]   r_acc_q;
    logic [LARG_BCD-1:0]   r_acc_r;
    logic                  r_dz;
    logic [LARG_BCD-1:0]   r_bcd_q;
    logic [LARG_BCD-1:0]   r_bcd_r;
    logic                  r_erro;
    logic                  r_busy;
    logic                  r_valid;

    logic [LARG_BCD-1:0]   w_adj_q;
    logic [LARG_BCD-1:0]   w_adj_r;
    logic [LARG_BCD-1:0]   w_prox_q;
    logic [LARG_BCD-1:0]   w_prox_r;

    // Digits are corrected independently; no carry crosses a digit boundary.
    for (genvar d = 0; d < DIGITOS; d++) begin : g_digito
        ajuste_mais3 u_ajuste_q (
            .digito_in  (r_acc_q[4*d +: 4]),
            .digito_out (w_adj_q[4*d +: 4])
        );
        ajuste_mais3 u_ajuste_r (
            .digito_in  (r_acc_r[4*d +: 4]),
            .digito_out (w_adj_r[4*d +: 4])
        );
    end

    assign w_prox_q = {w_adj_q[LARG_BCD-2:0], r_bin_q[LARGURA-1]};
    assign w_prox_r = {w_adj_r[LARG_BCD-2:0], r_bin_r[LARGURA-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
            r_bin_q  <= '0;
            r_bin_r  <= '0;
            r_acc_q  <= '0;
            r_acc_r  <= '0;
            r_dz     <= 1'b0;
            r_bcd_q  <= '0;
            r_bcd_r  <= '0;
            r_erro   <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (start) begin
                        r_bin_q  <= quociente;
                        r_bin_r  <= resto;
                        r_dz     <= div_zero;
                        r_acc_q  <= '0;
                        r_acc_r  <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_estado <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    r_acc_q <= w_prox_q;
                    r_acc_r <= w_prox_r;
                    r_bin_q <= r_bin_q << 1;
                    r_bin_r <= r_bin_r << 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Last shift: publish the post-shift accumulators directly.
                    if (r_cnt == c_CNT_ULT) begin
                        r_bcd_q  <= w_prox_q;
                        r_bcd_r  <= w_prox_r;
                        r_erro   <= r_dz;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_estado <= OCIOSO;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign bcd_q = r_bcd_q;
    assign bcd_r = r_bcd_r;
    assign erro  = r_erro;
    assign busy  = r_busy;
    assign valid = r_valid;

endmodule : conversor_bcd_resultado

`default_nettype wire

// File: tb/tb_conversor_bcd_resultado.sv
// ============================================================================
//  tb_conversor_bcd_resultado
//  Randomized self-checking bench against a decimal-arithmetic reference.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_conversor_bcd_resultado;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  quociente;
    logic [7:0]  resto;
    logic        div_zero;
    logic [11:0] bcd_q;
    logic [11:0] bcd_r;
    logic        erro;
    logic        busy;
    logic        valid;

    int n_checks;
    int n_fails;

    conversor_bcd_resultado #(
        .LARGURA (8),
        .DIGITOS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .quociente (quociente),
        .resto     (resto),
        .div_zero  (div_zero),
        .bcd_q     (bcd_q),
        .bcd_r     (bcd_r),
        .erro      (erro),
        .busy      (busy),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Decimal reference: digits from plain division, packed as nibbles.
    function automatic logic [11:0] bcd_ref(input int v);
        int c, d, u;
        c = v / 100;
        d = (v / 10) % 10;
        u = v % 10;
        return 12'((c << 8) | (d << 4) | u);
    endfunction

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic dispara(input logic [7:0] q, input logic [7:0] r, input logic dz);
        start     = 1'b1;
        quociente = q;
        resto     = r;
        div_zero  = dz;
        ciclo();
        start = 1'b0;
        verifica("busy_apos_start", 32'(busy), 32'd1);
    endtask

    // Walks the 8 conversion edges, scrambling operands each cycle and
    // optionally pulsing start at busy cycles 2 and 5. Ends with valid high.
    task automatic espera_resultado(input string tag, input logic [7:0] q, input logic [7:0] r,
                                    input logic dz, input bit injeta);
        for (int i = 1; i <= 8; i++) begin
            ciclo();
            if (i < 8) begin
                verifica({tag, "_valid_cedo"}, 32'(valid), 32'd0);
                verifica({tag, "_busy"}, 32'(busy), 32'd1);
            end
            quociente = 8'($urandom);
            resto     = 8'($urandom);
            div_zero  = 1'($urandom);
            start     = injeta && (i == 2 || i == 5);
        end
        start = 1'b0;
        verifica({tag, "_valid"}, 32'(valid), 32'd1);
        verifica({tag, "_busy_fim"}, 32'(busy), 32'd0);
        verifica({tag, "_bcd_q"}, 32'(bcd_q), 32'(bcd_ref(int'(q))));
        verifica({tag, "_bcd_r"}, 32'(bcd_r), 32'(bcd_ref(int'(r))));
        verifica({tag, "_erro"}, 32'(erro), 32'(dz));
    endtask

    task automatic ocioso_confere(input string tag, input logic [7:0] q, input logic [7:0] r,
                                  input logic dz);
        ciclo();
        verifica({tag, "_valid_unico"}, 32'(valid), 32'd0);
        verifica({tag, "_hold"}, 32'({bcd_q, bcd_r, erro}),
                 32'({bcd_ref(int'(q)), bcd_ref(int'(r)), dz}));
    endtask

    initial begin
        logic [7:0] q, r;
        logic       dz;
        int         n_valid;
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        quociente = '0;
        resto     = '0;
        div_zero  = 1'b0;
        repeat (3) ciclo();
        verifica("reset_saidas", 32'({bcd_q, bcd_r, erro, busy, valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ciclo();
        verifica("pos_reset_busy", 32'(busy), 32'd0);

        dispara(8'd42, 8'd5, 1'b0);
        espera_resultado("d42_5", 8'd42, 8'd5, 1'b0, 1'b0);
        ocioso_confere("d42_5", 8'd42, 8'd5, 1'b0);

        dispara(8'd255, 8'd199, 1'b0);
        espera_resultado("max", 8'd255, 8'd199, 1'b0, 1'b0);
        ocioso_confere("max", 8'd255, 8'd199, 1'b0);

        dispara(8'd0, 8'd0, 1'b1);
        espera_resultado("zero_dz", 8'd0, 8'd0, 1'b1, 1'b0);
        ocioso_confere("zero_dz", 8'd0, 8'd0, 1'b1);

        dispara(8'd137, 8'd64, 1'b0);
        espera_resultado("ignora_start", 8'd137, 8'd64, 1'b0, 1'b1);
        ocioso_confere("ignora_start", 8'd137, 8'd64, 1'b0);
        ciclo();
        verifica("ignora_start_sem_fila", 32'(busy), 32'd0);

        // Asynchronous reset mid-conversion must abort without a valid.
        dispara(8'd77, 8'd88, 1'b1);
        repeat (3) ciclo();
        #2;
        rst_n = 1'b0;
        #1;
        verifica("abort_saidas", 32'({bcd_q, bcd_r, erro, busy, valid}), 32'd0);
        repeat (2) ciclo();
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            ciclo();
            if (valid) n_valid++;
        end
        verifica("abort_sem_valid", 32'(n_valid), 32'd0);
        verifica("abort_busy", 32'(busy), 32'd0);

        dispara(8'd120, 8'd3, 1'b0);
        espera_resultado("pos_abort", 8'd120, 8'd3, 1'b0, 1'b0);
        // start in the valid cycle is accepted immediately
        dispara(8'd9, 8'd1, 1'b0);
        espera_resultado("b2b", 8'd9, 8'd1, 1'b0, 1'b0);
        ocioso_confere("b2b", 8'd9, 8'd1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            q  = 8'($urandom);
            r  = 8'($urandom);
            dz = 1'($urandom_range(0, 3) == 0);
            dispara(q, r, dz);
            espera_resultado("aleat", q, r, dz, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                ocioso_confere("aleat", q, r, dz);
                repeat ($urandom_range(0, 3)) ciclo();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_conversor_bcd_resultado

`default_nettype wire
